multicycle_controller: RTL

- Main control FSM for the multicycle RISC-V datapath.
- Generates ALUControl and the SrcA/SrcB mux selects that feed the ALU, consumes the ALU's Zero flag, and sequences instruction fetch and data memory access through the cache.
- Stalls in memory states while the cache reports a miss.

---
 rtl/multicycle_controller.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for the multicycle RISC-V datapath. It sequences fetch,
// decode, execute, memory access and writeback; drives the ALU operand
// selects and ALU operation; and waits in the memory states while the cache
// reports a miss. All outputs are decoded combinationally from the current
// state, plus Instr/Zero/Stall where noted.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST          in   asynchronous active-high reset (state -> FETCH)
//   Instr[31:0]  in   instruction register (opcode, funct3, funct7b5 used)
//   Zero         in   ALU zero flag
//   Stall        in   cache busy/miss; holds FETCH/MEMREAD/MEMWRITE
//   PCWrite      out  PC register enable
//   AdrSrc       out  memory address select (0 PC, 1 ALUOut)
//   MemRead      out  memory/cache read request
//   MemWrite     out  memory/cache write request
//   IRWrite      out  instruction register / OldPC enable
//   RegWrite     out  register file write enable
//   ResultSrc    out  00 ALUOut, 01 memory data, 10 ALUResult
//   ALUSrcA      out  00 PC, 01 OldPC, 10 rs1
//   ALUSrcB      out  00 rs2, 01 immediate, 10 constant 4
//   ALUControl   out  ALU operation code
//   ImmSrc       out  immediate format (00 I, 01 S, 10 B, 11 J)
//   IllegalInstr out  pulse in DECODE for an unsupported opcode
//   InstrRetired out  pulse on the final state of each instruction
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        Stall,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic        IllegalInstr,
  output logic        InstrRetired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state_q, state_d;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        unused_instr_bits;

  assign opcode   = Instr[6:0];
  assign funct3   = Instr[14:12];
  assign funct7b5 = Instr[30];
  assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

  // ALU operation from funct3; subtraction only when the caller allows it
  // (R-type with funct7b5 set).
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_en);
    logic [2:0] op;
    case (f3)
      3'b000:  op = sub_en ? 3'b001 : 3'b000;
      3'b001:  op = 3'b100;
      3'b010:  op = 3'b101;
      3'b101:  op = 3'b110;
      3'b110:  op = 3'b011;
      3'b111:  op = 3'b010;
      default: op = 3'b000;
    endcase
    return op;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= state_t'(RESET_STATE);
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = S_FETCH;
    PCWrite      = 1'b0;
    AdrSrc       = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUControl   = 3'b000;
    IllegalInstr = 1'b0;
    InstrRetired = 1'b0;

    // Immediate format depends only on the opcode, independent of state.
    case (opcode)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase

    case (state_q)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (Stall) begin
          state_d = S_FETCH;
        end else begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // OldPC + imm is parked in ALUOut for a later branch/jump.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            IllegalInstr = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        // opcode[5] separates store (1) from load (0).
        state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
        state_d = Stall ? S_MEMREAD : S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc    = 2'b01;
        RegWrite     = 1'b1;
        InstrRetired = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (Stall) begin
          state_d = S_MEMWRITE;
        end else begin
          InstrRetired = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = alu_dec(funct3, funct7b5);
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(funct3, 1'b0);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite     = 1'b1;
        InstrRetired = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        // PC <- jump target from ALUOut while OldPC + 4 becomes the link value.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b00;
        ALUControl   = 3'b001;
        // funct3[0] inverts the sense: beq takes on Zero, bne on !Zero.
        PCWrite      = Zero ^ funct3[0];
        InstrRetired = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule
